// File: rtl/imul_pkg.sv
// Shared definitions for the iterative integer multiplier.
//   imul_req_t   : request payload layout {a, b} at the 32-bit default width
//   imul_state_t : multiplier control states
package imul_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } imul_req_t;

    typedef enum logic [1:0] {
        IMUL_IDLE,
        IMUL_CALC,
        IMUL_DONE
    } imul_state_t;

endpackage

// File: rtl/int_mul_iter_dpath.sv
// Datapath of the iterative shift-add multiplier.
// Holds the shifting multiplicand (a_r), the shifting multiplier (b_r) and the
// running product (res_r).
//   clk, reset      clock, synchronous active-high reset (clears all registers)
//   load            capture a/b and clear the running product
//   step            perform one iteration (shift a_r left, b_r right)
//   add             accumulate a_r into res_r during this iteration
//   a, b            operands captured on load
//   res             running product, low DW bits
//   b_is_zero_next  high when b_r>>1 is zero, i.e. this is the last useful iteration
//   b_lsb           current multiplier bit
module int_mul_iter_dpath #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic          add,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          b_is_zero_next,
    output logic          b_lsb
);

    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [DW-1:0] res_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
        end else if (load) begin
            a_r   <= a;
            b_r   <= b;
            res_r <= '0;
        end else if (step) begin
            // Carry-out dropped: only the low DW bits of the product are kept.
            if (add) begin
                res_r <= res_r + a_r;
            end
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
        end
    end

    assign res            = res_r;
    assign b_lsb          = b_r[0];
    assign b_is_zero_next = (b_r[DW-1:1] == '0);

endmodule

// File: rtl/int_mul_iter.sv
// Iterative shift-add integer multiplier serving the MUL instruction.
// Returns the low DW bits of a*b (valid for signed and unsigned operands);
// latency depends on the position of the highest set bit of b.
//   clk       clock
//   reset     synchronous, active-high reset
//   req_val   request valid
//   req_rdy   request ready (registered; high only when idle)
//   req_msg   {a, b}: a multiplicand in the upper DW bits, b multiplier in the lower
//   resp_val  response valid (registered; high only when the result is held)
//   resp_rdy  response ready
//   resp_msg  (a*b) mod 2^DW
module int_mul_iter
    import imul_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_val,
    output logic            req_rdy,
    input  logic [2*DW-1:0] req_msg,
    output logic            resp_val,
    input  logic            resp_rdy,
    output logic [DW-1:0]   resp_msg
);

    localparam int unsigned CW = $clog2(DW);

    imul_state_t   state;
    logic [CW-1:0] cnt;

    logic          load;
    logic          step;
    logic          add;
    logic          last;
    logic          b_is_zero_next;
    logic          b_lsb;

    assign load = (state == IMUL_IDLE) && req_val;
    assign step = (state == IMUL_CALC);
    assign add  = step && b_lsb;
    // Stop once no set multiplier bits remain, or after DW iterations at most.
    assign last = b_is_zero_next || (cnt == CW'(DW - 1));

    int_mul_iter_dpath #(
        .DW (DW)
    ) u_dpath (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .step           (step),
        .add            (add),
        .a              (req_msg[2*DW-1:DW]),
        .b              (req_msg[DW-1:0]),
        .res            (resp_msg),
        .b_is_zero_next (b_is_zero_next),
        .b_lsb          (b_lsb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IMUL_IDLE;
            cnt      <= '0;
            req_rdy  <= 1'b1;
            resp_val <= 1'b0;
        end else begin
            case (state)
                IMUL_IDLE: begin
                    if (req_val) begin
                        cnt     <= '0;
                        state   <= IMUL_CALC;
                        req_rdy <= 1'b0;
                    end
                end
                IMUL_CALC: begin
                    if (last) begin
                        state    <= IMUL_DONE;
                        resp_val <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                IMUL_DONE: begin
                    if (resp_rdy) begin
                        state    <= IMUL_IDLE;
                        resp_val <= 1'b0;
                        req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IMUL_IDLE;
                    cnt      <= '0;
                    req_rdy  <= 1'b1;
                    resp_val <= 1'b0;
                end
            endcase
        end
    end

endmodule
